// File: rtl/alu_pkg.sv
// Shared ALU encodings, operand select codes and datapath widths
// used by the decode/execute pipeline register and its forwarding logic.
package alu_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  localparam logic ASEL_RS1 = 1'b0;
  localparam logic ASEL_PC  = 1'b1;
  localparam logic BSEL_RS2 = 1'b0;
  localparam logic BSEL_IMM = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_st_e;

endpackage

// File: rtl/fwd_unit.sv
// Per-operand bypass select: EX/MEM beats MEM/WB, x0 never bypassed.
// hit reports any producer match so the caller can interlock instead.
module fwd_unit #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter bit FWD_EN  = 1'b1
) (
  input  logic [RADDR_W-1:0] rs_addr,
  input  logic [XLEN-1:0]    rf_data,
  input  logic [RADDR_W-1:0] exmem_rd,
  input  logic               exmem_wen,
  input  logic [XLEN-1:0]    exmem_data,
  input  logic [RADDR_W-1:0] memwb_rd,
  input  logic               memwb_wen,
  input  logic [XLEN-1:0]    memwb_data,
  output logic [XLEN-1:0]    fwd_data,
  output logic               hit
);

  logic ex_hit;
  logic wb_hit;

  // match against both downstream producers and pick the youngest
  always_comb begin
    ex_hit = exmem_wen && (exmem_rd == rs_addr)
             && (rs_addr != '0);
    wb_hit = memwb_wen && (memwb_rd == rs_addr)
             && (rs_addr != '0);
    hit    = ex_hit || wb_hit;
    fwd_data = rf_data;
    if (FWD_EN && ex_hit)
      fwd_data = exmem_data;
    else if (FWD_EN && wb_hit)
      fwd_data = memwb_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode/execute pipeline register with valid/ready handshake.
// ID_EX_FORWARD_EN: bypass from EX/MEM, MEM/WB; else interlock on hazard.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int XLEN    = alu_pkg::XLEN,
  parameter int RADDR_W = alu_pkg::RADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    pc,
  input  logic [XLEN-1:0]    rs1Data,
  input  logic [XLEN-1:0]    rs2Data,
  input  logic [XLEN-1:0]    imm,
  input  logic [RADDR_W-1:0] rs1Addr,
  input  logic [RADDR_W-1:0] rs2Addr,
  input  logic [RADDR_W-1:0] rdAddr,
  input  logic               ASel,
  input  logic               BSel,
  input  logic [3:0]         ALUSelIn,
  input  logic               regWEnIn,
  input  logic               flush,
  input  logic [RADDR_W-1:0] exmemRd,
  input  logic [RADDR_W-1:0] memwbRd,
  input  logic               exmemWEn,
  input  logic               memwbWEn,
  input  logic [XLEN-1:0]    exmemData,
  input  logic [XLEN-1:0]    memwbData,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    inputA,
  output logic [XLEN-1:0]    inputB,
  output logic [3:0]         ALUSel,
  output logic [RADDR_W-1:0] rdAddrOut,
  output logic               regWEnOut,
  output logic [XLEN-1:0]    pcOut,
  output logic [XLEN-1:0]    storeData
);

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  stage_st_e          state_q, state_d;
  logic [XLEN-1:0]    a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]    pc_q, pc_d, sd_q, sd_d;
  logic [3:0]         alu_q, alu_d;
  logic [RADDR_W-1:0] rd_q, rd_d;
  logic               wen_q, wen_d;
  logic [XLEN-1:0]    fwd_a, fwd_b;
  logic               hit_a, hit_b;
  logic               stall, accept, drain;

  fwd_unit #(
    .XLEN(XLEN), .RADDR_W(RADDR_W), .FWD_EN(FWD_EN)
  ) u_fwd_a (
    .rs_addr(rs1Addr), .rf_data(rs1Data),
    .exmem_rd(exmemRd), .exmem_wen(exmemWEn),
    .exmem_data(exmemData),
    .memwb_rd(memwbRd), .memwb_wen(memwbWEn),
    .memwb_data(memwbData),
    .fwd_data(fwd_a), .hit(hit_a)
  );

  fwd_unit #(
    .XLEN(XLEN), .RADDR_W(RADDR_W), .FWD_EN(FWD_EN)
  ) u_fwd_b (
    .rs_addr(rs2Addr), .rf_data(rs2Data),
    .exmem_rd(exmemRd), .exmem_wen(exmemWEn),
    .exmem_data(exmemData),
    .memwb_rd(memwbRd), .memwb_wen(memwbWEn),
    .memwb_data(memwbData),
    .fwd_data(fwd_b), .hit(hit_b)
  );

  // handshake: free slot or draining, minus hazard interlock
  always_comb begin
    stall    = !FWD_EN && in_valid && (hit_a || hit_b);
    in_ready = ((state_q == ST_EMPTY) || out_ready) && !stall;
    accept   = in_valid && in_ready && !flush;
    drain    = (state_q == ST_FULL) && out_ready;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // next state: flush dominates, then accept, then drain
  always_comb begin
    state_d = state_q;
    if (flush)       state_d = ST_EMPTY;
    else if (accept) state_d = ST_FULL;
    else if (drain)  state_d = ST_EMPTY;
  end

  // output decode of the state
  always_comb begin
    out_valid = (state_q == ST_FULL);
  end

  // payload loads on accept only; write enable dies with the slot
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    pc_d  = pc_q;
    sd_d  = sd_q;
    alu_d = alu_q;
    rd_d  = rd_q;
    wen_d = wen_q;
    if (accept) begin
      a_d   = (ASel == ASEL_PC)  ? pc  : fwd_a;
      b_d   = (BSel == BSEL_IMM) ? imm : fwd_b;
      pc_d  = pc;
      sd_d  = fwd_b;
      alu_d = ALUSelIn;
      rd_d  = rdAddr;
    end
    if (flush)       wen_d = 1'b0;
    else if (accept) wen_d = regWEnIn;
    else if (drain)  wen_d = 1'b0;
  end

  // payload registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      pc_q  <= '0;
      sd_q  <= '0;
      alu_q <= ALU_ADD;
      rd_q  <= '0;
      wen_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      pc_q  <= pc_d;
      sd_q  <= sd_d;
      alu_q <= alu_d;
      rd_q  <= rd_d;
      wen_q <= wen_d;
    end
  end

  assign inputA    = a_q;
  assign inputB    = b_q;
  assign pcOut     = pc_q;
  assign storeData = sd_q;
  assign ALUSel    = alu_q;
  assign rdAddrOut = rd_q;
  assign regWEnOut = wen_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios then random traffic,
// all checked against a transaction-level model of the stage.
module tb_id_ex_stage;

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] pc, rs1Data, rs2Data, imm;
  logic [4:0]  rs1Addr, rs2Addr, rdAddr;
  logic        ASel, BSel;
  logic [3:0]  ALUSelIn;
  logic        regWEnIn, flush;
  logic [4:0]  exmemRd, memwbRd;
  logic        exmemWEn, memwbWEn;
  logic [31:0] exmemData, memwbData;
  logic        out_valid, out_ready;
  logic [31:0] inputA, inputB, pcOut, storeData;
  logic [3:0]  ALUSel;
  logic [4:0]  rdAddrOut;
  logic        regWEnOut;

  int n_chk = 0;
  int n_err = 0;

  bit          m_valid;
  logic [31:0] m_a, m_b, m_pc, m_sd;
  logic [3:0]  m_alu;
  logic [4:0]  m_rd;
  logic        m_wen;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .rs1Data(rs1Data), .rs2Data(rs2Data), .imm(imm),
    .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rdAddr(rdAddr),
    .ASel(ASel), .BSel(BSel),
    .ALUSelIn(ALUSelIn), .regWEnIn(regWEnIn), .flush(flush),
    .exmemRd(exmemRd), .memwbRd(memwbRd),
    .exmemWEn(exmemWEn), .memwbWEn(memwbWEn),
    .exmemData(exmemData), .memwbData(memwbData),
    .out_valid(out_valid), .out_ready(out_ready),
    .inputA(inputA), .inputB(inputB), .ALUSel(ALUSel),
    .rdAddrOut(rdAddrOut), .regWEnOut(regWEnOut),
    .pcOut(pcOut), .storeData(storeData)
  );

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit produced(logic [4:0] a);
    return (a != 0) &&
      ((exmemWEn && exmemRd == a) ||
       (memwbWEn && memwbRd == a));
  endfunction

  function automatic logic [31:0] operand(logic [4:0] a,
                                          logic [31:0] rf);
    if (FWD && a != 0 && exmemWEn && exmemRd == a)
      return exmemData;
    if (FWD && a != 0 && memwbWEn && memwbRd == a)
      return memwbData;
    return rf;
  endfunction

  function automatic bit exp_ready();
    bit hz;
    hz = !FWD && in_valid && (produced(rs1Addr) || produced(rs2Addr));
    return (!m_valid || out_ready) && !hz;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_a = 0; m_b = 0; m_pc = 0; m_sd = 0;
    m_alu = 0; m_rd = 0; m_wen = 0;
  endtask

  task automatic chk_outs(string tag);
    chk({tag, "_ov"}, {31'b0, out_valid}, {31'b0, m_valid});
    chk({tag, "_we"}, {31'b0, regWEnOut}, {31'b0, m_wen});
    chk({tag, "_a"}, inputA, m_a);
    chk({tag, "_b"}, inputB, m_b);
    chk({tag, "_pc"}, pcOut, m_pc);
    chk({tag, "_sd"}, storeData, m_sd);
    chk({tag, "_alu"}, {28'b0, ALUSel}, {28'b0, m_alu});
    chk({tag, "_rd"}, {27'b0, rdAddrOut}, {27'b0, m_rd});
  endtask

  // inputs are already applied; check ready, clock, check outputs
  task automatic step(string tag);
    bit rdy, take;
    logic [31:0] op1, op2;
    #1;
    rdy = exp_ready();
    chk({tag, "_rdy"}, {31'b0, in_ready}, {31'b0, rdy});
    take = in_valid && rdy && !flush;
    op1 = operand(rs1Addr, rs1Data);
    op2 = operand(rs2Addr, rs2Data);
    @(posedge clk);
    #1;
    if (flush) begin
      m_valid = 0; m_wen = 0;
    end else if (take) begin
      m_valid = 1;
      m_a = ASel ? pc : op1;
      m_b = BSel ? imm : op2;
      m_sd = op2; m_pc = pc; m_alu = ALUSelIn;
      m_rd = rdAddr; m_wen = regWEnIn;
    end else if (m_valid && out_ready) begin
      m_valid = 0; m_wen = 0;
    end
    chk_outs(tag);
  endtask

  task automatic idle();
    in_valid = 0; pc = 0; rs1Data = 0; rs2Data = 0; imm = 0;
    rs1Addr = 0; rs2Addr = 0; rdAddr = 0; ASel = 0; BSel = 0;
    ALUSelIn = 0; regWEnIn = 0; flush = 0;
    exmemRd = 0; memwbRd = 0; exmemWEn = 0; memwbWEn = 0;
    exmemData = 0; memwbData = 0; out_ready = 1;
  endtask

  task automatic instr(logic [31:0] d1, logic [31:0] d2,
                       logic [4:0] rd);
    in_valid = 1; rs1Data = d1; rs2Data = d2; rdAddr = rd;
    rs1Addr = 1; rs2Addr = 2; regWEnIn = 1; ALUSelIn = 4'b0000;
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 0;
    #2;
    chk("rst_ov", {31'b0, out_valid}, 32'd0);
    chk("rst_a", inputA, 32'd0);
    chk("rst_sd", storeData, 32'd0);
    @(negedge clk);
    rst_n = 1;

    // basic add operands
    instr(32'hFFFF_FFFE, 32'd2, 5'd3);
    step("r29");
    chk("r29_a_k", inputA, 32'hFFFF_FFFE);
    chk("r29_b_k", inputB, 32'd2);
    chk("r29_v_k", {31'b0, out_valid}, 32'd1);

    // pc/imm selection, storeData keeps rs2
    instr(32'h1234, 32'h5678, 5'd4);
    ASel = 1; BSel = 1; pc = 32'h8000_0000;
    imm = 32'hFFFF_F800; ALUSelIn = 4'b1000;
    step("r33");
    chk("r33_a_k", inputA, 32'h8000_0000);
    chk("r33_b_k", inputB, 32'hFFFF_F800);
    chk("r33_sd_k", storeData, 32'h5678);
    chk("r33_alu_k", {28'b0, ALUSel}, 32'h8);
    ASel = 0; BSel = 0; ALUSelIn = 0;

`ifdef ID_EX_FORWARD_EN
    instr(32'h99, 32'h0, 5'd6);
    rs1Addr = 5; rs2Addr = 0;
    exmemRd = 5; exmemWEn = 1; exmemData = 32'h11;
    memwbRd = 5; memwbWEn = 1; memwbData = 32'h22;
    step("r30a");
    chk("r30a_k", inputA, 32'h11);
    rs1Addr = 0;
    step("r30b");
    chk("r30b_k", inputA, 32'h99);
    idle();
`else
    instr(32'h1, 32'h2, 5'd6);
    rs2Addr = 7; exmemRd = 7; exmemWEn = 1;
    step("r34s");
    chk("r34s_k", {31'b0, in_ready}, 32'd0);
    step("r34s2");
    exmemWEn = 0;
    step("r34c");
    chk("r34c_v", {31'b0, out_valid}, 32'd1);
    idle();
`endif

    // back-pressure for three cycles
    instr(32'hA, 32'hB, 5'd8);
    step("r31f");
    instr(32'hC, 32'hD, 5'd9);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step("r31h");
      chk("r31h_a_k", inputA, 32'hA);
    end
    out_ready = 1;
    step("r31r");
    chk("r31r_a_k", inputA, 32'hC);

    // flush with incoming instruction while full
    instr(32'hE, 32'hF, 5'd10);
    flush = 1;
    step("r32");
    chk("r32_v_k", {31'b0, out_valid}, 32'd0);
    chk("r32_we_k", {31'b0, regWEnOut}, 32'd0);
    flush = 0;
    idle();
    step("r32i");

    // asynchronous reset mid-full
    instr(32'h55, 32'h66, 5'd11);
    out_ready = 0;
    step("r34f");
    #2;
    rst_n = 0;
    #1;
    model_reset();
    chk("r34r_v", {31'b0, out_valid}, 32'd0);
    chk("r34r_we", {31'b0, regWEnOut}, 32'd0);
    chk("r34r_a", inputA, 32'd0);
    @(negedge clk);
    rst_n = 1;
    idle();
    step("r34p");

    // random traffic with narrow register ranges to provoke hits
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      flush = ($urandom_range(7) == 0);
      pc = $urandom; rs1Data = $urandom; rs2Data = $urandom;
      imm = $urandom;
      rs1Addr = 5'($urandom_range(7));
      rs2Addr = 5'($urandom_range(7));
      rdAddr = 5'($urandom);
      ASel = 1'($urandom); BSel = 1'($urandom);
      ALUSelIn = 4'($urandom); regWEnIn = 1'($urandom);
      exmemRd = 5'($urandom_range(7));
      memwbRd = 5'($urandom_range(7));
      exmemWEn = 1'($urandom); memwbWEn = 1'($urandom);
      exmemData = $urandom; memwbData = $urandom;
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, 32, operand/data width.
REQ-002 Parameter RADDR_W, 5, register address width.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  decoded instruction present; in_ready  output  1  stage can accept.
REQ-006 pc, rs1Data, rs2Data, imm  input  XLEN each  decoded operands.
REQ-007 rs1Addr, rs2Addr, rdAddr  input  RADDR_W each  source/destination register indices.
REQ-008 ASel  input  1  0=rs1, 1=pc; BSel  input  1  0=rs2, 1=imm.
REQ-009 ALUSelIn  input  4  ALU op code; regWEnIn  input  1  writes rd.
REQ-010 flush  input  1  kill held and incoming instruction.
REQ-011 exmemRd, memwbRd  input  RADDR_W; exmemWEn, memwbWEn  input  1; exmemData, memwbData  input  XLEN  downstream writeback sources.
REQ-012 out_valid  output  1; out_ready  input  1  ALU-side handshake.
REQ-013 inputA, inputB  output  XLEN  registered ALU operands; ALUSel  output  4.
REQ-014 rdAddrOut  output  RADDR_W; regWEnOut  output  1; pcOut  output  XLEN; storeData  output  XLEN  forwarded rs2.

Function
REQ-015 Two states: EMPTY (out_valid=0), FULL (out_valid=1); one instruction held max.
REQ-016 in_ready = !out_valid || out_ready (combinational), subject to REQ-026.
REQ-017 Accept on in_valid && in_ready at rising clk; outputs update same edge; latency 1 cycle.
REQ-018 EMPTY->FULL on accept; FULL->EMPTY on out_ready && !accept; FULL->FULL on simultaneous drain+accept.
REQ-019 FULL && !out_ready: all outputs held bit-stable.
REQ-020 Forwarding per source: exmemWEn && exmemRd==rsX && rsX!=0 selects exmemData; else same test on MEM/WB selects memwbData; else register-file data.
REQ-021 EX/MEM has priority over MEM/WB on double match; x0 never forwarded.
REQ-022 inputA = ASel ? pc : fwd rs1; inputB = BSel ? imm : fwd rs2; storeData = fwd rs2 regardless of BSel.
REQ-023 flush: next edge out_valid=0, regWEnOut=0; incoming in_valid that cycle dropped; flush wins over accept and drain.
REQ-024 Data outputs not cleared on flush/drain; only out_valid and regWEnOut cleared.

Reset
REQ-025 rst_n low: immediately out_valid=0, regWEnOut=0, inputA=inputB=pcOut=storeData=0, ALUSel=4'b0000 (add), rdAddrOut=0; in_ready=1 once released; reset mid-handshake discards held instruction.

Configuration
REQ-026 Macro ID_EX_FORWARD_EN: defined -> REQ-020..021 forwarding active, in_ready per REQ-016; undefined -> forward data ports ignored, operands from rs1Data/rs2Data only, in_ready additionally forced 0 while in_valid and any REQ-020 match exists (interlock stall).

Structure
REQ-027 Shared package alu_pkg: XLEN, RADDR_W, ALU op encodings (add 0000, sub 1000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101, sra 1101, or 0110, and 0111), ASel/BSel encodings.
REQ-028 Forwarding comparison in sub-module fwd_unit (one instance per source operand); pipeline register and handshake in id_ex_stage.

Verification
REQ-029 rs1Data=0xFFFFFFFE, rs2Data=2, ASel=BSel=0, ALUSelIn=add, out_ready=1 -> next cycle out_valid=1, inputA=0xFFFFFFFE, inputB=2, ALUSel=0000.
REQ-030 rs1Addr=5, exmemRd=5 exmemWEn=1 exmemData=0x11, memwbRd=5 memwbWEn=1 memwbData=0x22 -> inputA=0x11 (forward-on); rs1Addr=0 with same -> inputA=rs1Data.
REQ-031 out_ready=0 for 3 cycles while FULL, new in_valid presented -> in_ready=0, outputs unchanged, second instruction captured on the cycle out_ready rises.
REQ-032 flush and in_valid asserted same cycle while FULL -> next cycle out_valid=0, regWEnOut=0, no instruction emitted.
REQ-033 ASel=1 pc=0x80000000, BSel=1 imm=0xFFFFF800, ALUSelIn=sub -> inputA=0x80000000, inputB=0xFFFFF800, storeData=fwd rs2.
REQ-034 rst_n low mid-FULL, asynchronous to clk -> out_valid=0 and regWEnOut=0 before next edge; forward-off build with rs2Addr=exmemRd=7, exmemWEn=1 -> in_ready=0 until match clears.
